// File: rtl/dpram_pkg.sv
// dpram_be shared package: read-during-write mode constants,
// clear sequencer state type and byte-lane count helper.
package dpram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    function automatic int lane_count(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/dpram_be_if.sv
// dpram_be bus bundle: clear control plus both access ports.
// master drives requests, slave is the RAM.
interface dpram_be_if
    import dpram_pkg::*;
#(
    parameter int dWidth = 16,
    parameter int aWidth = 10,
    parameter int bWidth = 8
);
    localparam int NB = lane_count(dWidth, bWidth);

    logic              clr;
    logic              busy;
    logic              coll;
    logic              en_a;
    logic [NB-1:0]     we_a;
    logic [aWidth-1:0] addr_a;
    logic [dWidth-1:0] d_a;
    logic [dWidth-1:0] q_a;
    logic              valid_a;
    logic              en_b;
    logic [NB-1:0]     we_b;
    logic [aWidth-1:0] addr_b;
    logic [dWidth-1:0] d_b;
    logic [dWidth-1:0] q_b;
    logic              valid_b;

    modport master (
        output clr, en_a, we_a, addr_a, d_a,
        output en_b, we_b, addr_b, d_b,
        input  busy, coll, q_a, valid_a, q_b, valid_b
    );

    modport slave (
        input  clr, en_a, we_a, addr_a, d_a,
        input  en_b, we_b, addr_b, d_b,
        output busy, coll, q_a, valid_a, q_b, valid_b
    );

endinterface

// File: rtl/dpram_clr_ctrl.sv
// dpram_be clear sequencer: walks every address once writing zero,
// then returns to idle with the counter wrapped back to 0.
module dpram_clr_ctrl
    import dpram_pkg::*;
#(
    parameter int aWidth = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [aWidth-1:0] clr_addr_o
);

    clr_state_e        state_q;
    logic [aWidth-1:0] cnt_q;
    logic              busy_q;

    // Clear FSM: start on clr when idle, stop after the top address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                CLR_IDLE: begin
                    if (clr_i) begin
                        state_q <= CLR_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= CLR_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLR_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dpram_be.sv
// dpram_be: single-clock true dual-port RAM with byte enables.
// Optional collision flag: define DPRAM_BE_COLLISION_EN.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int dWidth   = 16,
    parameter int aWidth   = 10,
    parameter int bWidth   = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_WRITE_FIRST
) (
    input logic       clk,
    input logic       rst_n,
    dpram_be_if.slave bus
);

    localparam int NB    = lane_count(dWidth, bWidth);
    localparam int DEPTH = 2 ** aWidth;

    if (dWidth % bWidth != 0) begin : g_bad_lanes
        $error("dpram_be: dWidth must be a multiple of bWidth");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("dpram_be: RD_LAT must be 1 or 2");
    end

    logic              busy;
    logic              clr_we;
    logic [aWidth-1:0] clr_addr;

    dpram_clr_ctrl #(
        .aWidth(aWidth)
    ) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (bus.clr),
        .busy_o    (busy),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign bus.busy = busy;

    logic acc_a;
    logic acc_b;

    assign acc_a = bus.en_a & ~busy;
    assign acc_b = bus.en_b & ~busy;

    logic [dWidth-1:0] mem [DEPTH];
    logic [dWidth-1:0] old_a, old_b;
    logic [dWidth-1:0] mrg_a, mrg_b;
    logic [dWidth-1:0] rd_a, rd_b;

    assign old_a = mem[bus.addr_a];
    assign old_b = mem[bus.addr_b];

    // Same-port merged word: written lanes new, others pre-write
    always_comb begin
        mrg_a = old_a;
        mrg_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (bus.we_a[i]) mrg_a[i*bWidth +: bWidth] = bus.d_a[i*bWidth +: bWidth];
            if (bus.we_b[i]) mrg_b[i*bWidth +: bWidth] = bus.d_b[i*bWidth +: bWidth];
        end
    end

    assign rd_a = (RDW_MODE == RDW_READ_FIRST) ? old_a : mrg_a;
    assign rd_b = (RDW_MODE == RDW_READ_FIRST) ? old_b : mrg_b;

    // Array write: clear owns the array; B before A so A wins shared lanes
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (acc_b && bus.we_b[i])
                    mem[bus.addr_b][i*bWidth +: bWidth] <= bus.d_b[i*bWidth +: bWidth];
                if (acc_a && bus.we_a[i])
                    mem[bus.addr_a][i*bWidth +: bWidth] <= bus.d_a[i*bWidth +: bWidth];
            end
        end
    end

    logic [dWidth-1:0] q1a_q, q1b_q;
    logic              v1a_q, v1b_q;

    // First read stage: capture the returned word, hold it otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1a_q <= '0;
            q1b_q <= '0;
            v1a_q <= 1'b0;
            v1b_q <= 1'b0;
        end else begin
            v1a_q <= acc_a;
            v1b_q <= acc_b;
            if (acc_a) q1a_q <= rd_a;
            if (acc_b) q1b_q <= rd_b;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [dWidth-1:0] q2a_q, q2b_q;
        logic              v2a_q, v2b_q;

        // Output stage: forward stage-one results one cycle later
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q2a_q <= '0;
                q2b_q <= '0;
                v2a_q <= 1'b0;
                v2b_q <= 1'b0;
            end else begin
                v2a_q <= v1a_q;
                v2b_q <= v1b_q;
                if (v1a_q) q2a_q <= q1a_q;
                if (v1b_q) q2b_q <= q1b_q;
            end
        end

        assign bus.q_a     = q2a_q;
        assign bus.q_b     = q2b_q;
        assign bus.valid_a = v2a_q;
        assign bus.valid_b = v2b_q;
    end else begin : g_lat1
        assign bus.q_a     = q1a_q;
        assign bus.q_b     = q1b_q;
        assign bus.valid_a = v1a_q;
        assign bus.valid_b = v1b_q;
    end

`ifdef DPRAM_BE_COLLISION_EN
    logic coll_q;

    // Flag same-address accesses on both ports where either writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= acc_a & acc_b & (bus.addr_a == bus.addr_b)
                    & ((|bus.we_a) | (|bus.we_b));
        end
    end

    assign bus.coll = coll_q;
`else
    assign bus.coll = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_be.sv
// dpram_be bench: two instances (lat 1 write-first, lat 2 read-first)
// on shared stimulus, checked against a word-level memory model.
module tb_dpram_be;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr;
    logic       en_a, en_b;
    logic [1:0] we_a, we_b;
    logic [9:0] addr_a, addr_b;
    logic [15:0] d_a, d_b;

    int vec = 0;
    int err = 0;

`ifdef DPRAM_BE_COLLISION_EN
    localparam logic COLL_EXP = 1'b1;
`else
    localparam logic COLL_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    dpram_be_if #(.dWidth(16), .aWidth(10), .bWidth(8)) if0 ();
    dpram_be_if #(.dWidth(16), .aWidth(10), .bWidth(8)) if1 ();

    assign if0.clr = clr;    assign if1.clr = clr;
    assign if0.en_a = en_a;  assign if1.en_a = en_a;
    assign if0.we_a = we_a;  assign if1.we_a = we_a;
    assign if0.addr_a = addr_a; assign if1.addr_a = addr_a;
    assign if0.d_a = d_a;    assign if1.d_a = d_a;
    assign if0.en_b = en_b;  assign if1.en_b = en_b;
    assign if0.we_b = we_b;  assign if1.we_b = we_b;
    assign if0.addr_b = addr_b; assign if1.addr_b = addr_b;
    assign if0.d_b = d_b;    assign if1.d_b = d_b;

    dpram_be #(.dWidth(16), .aWidth(10), .bWidth(8), .RD_LAT(1), .RDW_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dpram_be #(.dWidth(16), .aWidth(10), .bWidth(8), .RD_LAT(2), .RDW_MODE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // ---------------- reference model ----------------
    logic [15:0] mm [1024];
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    logic [15:0] e_qa [2] = '{16'h0, 16'h0};
    logic [15:0] e_qb [2] = '{16'h0, 16'h0};
    bit          e_va [2] = '{1'b0, 1'b0};
    bit          e_vb [2] = '{1'b0, 1'b0};
    bit          e_coll = 1'b0;
    logic [15:0] h_qa = 16'h0, h_qb = 16'h0;
    bit          h_va = 1'b0, h_vb = 1'b0;
    int          va0 = 0, vb0 = 0, va1 = 0, vb1 = 0;

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] we);
        return {we[1] ? n[15:8] : o[15:8], we[0] ? n[7:0] : o[7:0]};
    endfunction

    task automatic model_step();
        bit aa, ab;
        logic [15:0] oa, ob, wa, wb;
        if (!rst_n) begin
            if (m_busy) for (int i = m_cnt; i < 1024; i++) mm[i] = 'x;
            m_busy = 1'b0;
            m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                e_qa[k] = 16'h0; e_qb[k] = 16'h0;
                e_va[k] = 1'b0;  e_vb[k] = 1'b0;
            end
            h_qa = 16'h0; h_qb = 16'h0; h_va = 1'b0; h_vb = 1'b0;
            e_coll = 1'b0;
            return;
        end
        aa = en_a && !m_busy;
        ab = en_b && !m_busy;
        oa = mm[addr_a];
        ob = mm[addr_b];
        wa = merge(oa, d_a, we_a);
        wb = merge(ob, d_b, we_b);
        // instance 0: result right after the edge, new data on own write
        e_va[0] = aa; if (aa) e_qa[0] = wa;
        e_vb[0] = ab; if (ab) e_qb[0] = wb;
        // instance 1: result one edge later, pre-write data
        e_va[1] = h_va; if (h_va) e_qa[1] = h_qa;
        e_vb[1] = h_vb; if (h_vb) e_qb[1] = h_qb;
        h_va = aa; if (aa) h_qa = oa;
        h_vb = ab; if (ab) h_qb = ob;
        e_coll = COLL_EXP && aa && ab && addr_a == addr_b && (we_a != 0 || we_b != 0);
        if (m_busy) begin
            mm[m_cnt] = 16'h0;
            m_cnt++;
            if (m_cnt == 1024) begin
                m_busy = 1'b0;
                m_cnt = 0;
            end
        end else begin
            if (ab) mm[addr_b] = merge(mm[addr_b], d_b, we_b);
            if (aa) mm[addr_a] = merge(mm[addr_a], d_a, we_a);
            if (clr) begin
                m_busy = 1'b1;
                m_cnt = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            if (err <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic dut_cmp(input string t, input int k, input logic bz, input logic va,
                           input logic vb, input logic co, input logic [15:0] qa,
                           input logic [15:0] qb);
        chk({t, ".busy"}, 16'(bz), 16'(m_busy));
        chk({t, ".valid_a"}, 16'(va), 16'(e_va[k]));
        chk({t, ".valid_b"}, 16'(vb), 16'(e_vb[k]));
        chk({t, ".coll"}, 16'(co), 16'(e_coll));
        if (!$isunknown(e_qa[k])) chk({t, ".q_a"}, qa, e_qa[k]);
        if (!$isunknown(e_qb[k])) chk({t, ".q_b"}, qb, e_qb[k]);
    endtask

    initial forever begin
        @(negedge clk);
        dut_cmp("d0", 0, if0.busy, if0.valid_a, if0.valid_b, if0.coll, if0.q_a, if0.q_b);
        dut_cmp("d1", 1, if1.busy, if1.valid_a, if1.valid_b, if1.coll, if1.q_a, if1.q_b);
        va0 += int'(if0.valid_a); vb0 += int'(if0.valid_b);
        va1 += int'(if1.valid_a); vb1 += int'(if1.valid_b);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        clr = 1'b0;
        en_a = 1'b0; we_a = 2'b00; addr_a = '0; d_a = '0;
        en_b = 1'b0; we_b = 2'b00; addr_b = '0; d_b = '0;
    endtask

    task automatic cyc(input logic ea, input logic [1:0] wa, input logic [9:0] aa,
                       input logic [15:0] da, input logic eb, input logic [1:0] wb,
                       input logic [9:0] ab, input logic [15:0] db);
        en_a = ea; we_a = wa; addr_a = aa; d_a = da;
        en_b = eb; we_b = wb; addr_b = ab; d_b = db;
        @(negedge clk);
        idle();
    endtask

    task automatic do_clear(input bit poke, output int n0, output int n1, output int nv);
        n0 = 0; n1 = 0; nv = 0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        while ((if0.busy || if1.busy) && (n0 + n1) < 4000) begin
            n0 += int'(if0.busy);
            n1 += int'(if1.busy);
            nv += int'(if0.valid_a) + int'(if0.valid_b) + int'(if1.valid_a) + int'(if1.valid_b);
            if (poke) begin
                en_a = 1'b1; we_a = 2'b00; addr_a = n0[9:0];
                en_b = 1'b1; we_b = 2'b11; addr_b = n0[9:0]; d_b = 16'hDEAD;
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n0, n1, nv;
        int c0, c1, c2, c3;
        idle();
        repeat (3) @(negedge clk);
        chk("rst.busy", 16'(if0.busy), 16'h0);
        chk("rst.q_a0", if0.q_a, 16'h0);
        chk("rst.q_b1", if1.q_b, 16'h0);
        chk("rst.valid_b1", 16'(if1.valid_b), 16'h0);
        rst_n = 1'b1;

        do_clear(1'b0, n0, n1, nv);
        chk("clr1.cycles0", 16'(n0), 16'd1024);
        chk("clr1.cycles1", 16'(n1), 16'd1024);

        // partial write then cross-port read
        cyc(1, 2'b11, 10'h010, 16'h1234, 0, 2'b00, 10'h0, 16'h0);
        cyc(1, 2'b01, 10'h010, 16'hBEEF, 0, 2'b00, 10'h0, 16'h0);
        cyc(0, 2'b00, 10'h0, 16'h0, 1, 2'b00, 10'h010, 16'h0);
        chk("pw.valid_b0", 16'(if0.valid_b), 16'h1);
        chk("pw.q_b0", if0.q_b, 16'h12EF);
        @(negedge clk);
        chk("pw.valid_b0_pulse", 16'(if0.valid_b), 16'h0);
        chk("pw.valid_b1", 16'(if1.valid_b), 16'h1);
        chk("pw.q_b1", if1.q_b, 16'h12EF);

        // same-port write with cross-port read of a zero word
        cyc(1, 2'b11, 10'h020, 16'hAAAA, 1, 2'b00, 10'h020, 16'h0);
        chk("rdw.q_a0", if0.q_a, 16'hAAAA);
        chk("rdw.q_b0", if0.q_b, 16'h0000);
        @(negedge clk);
        chk("rdw.q_a1", if1.q_a, 16'h0000);
        chk("rdw.q_b1", if1.q_b, 16'h0000);

        // dual write to the top address
        cyc(1, 2'b11, 10'h3FF, 16'h1111, 1, 2'b10, 10'h3FF, 16'h2222);
        chk("coll.d0", 16'(if0.coll), 16'(COLL_EXP));
        cyc(1, 2'b00, 10'h3FF, 16'h0, 0, 2'b00, 10'h0, 16'h0);
        chk("coll.after", 16'(if0.coll), 16'h0);
        chk("dw.q_a0", if0.q_a, 16'h1111);
        @(negedge clk);
        chk("dw.q_a1", if1.q_a, 16'h1111);

        // fill with ones, clear with dropped requests, sweep
        for (int i = 0; i < 512; i++)
            cyc(1, 2'b11, 10'(2 * i), 16'hFFFF, 1, 2'b11, 10'(2 * i + 1), 16'hFFFF);
        do_clear(1'b1, n0, n1, nv);
        chk("clr2.cycles0", 16'(n0), 16'd1024);
        chk("clr2.cycles1", 16'(n1), 16'd1024);
        chk("clr2.valids", 16'(nv), 16'd0);
        for (int i = 0; i < 512; i++)
            cyc(1, 2'b00, 10'(2 * i), 16'h0, 1, 2'b00, 10'(2 * i + 1), 16'h0);
        @(negedge clk);
        chk("sweep.q_a0", if0.q_a, 16'h0000);
        chk("sweep.q_b1", if1.q_b, 16'h0000);

        // reset in the middle of a clear
        cyc(1, 2'b11, 10'h005, 16'h5A5A, 0, 2'b00, 10'h0, 16'h0);
        cyc(1, 2'b00, 10'h005, 16'h0, 1, 2'b00, 10'h005, 16'h0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (499) @(negedge clk);
        chk("mid.busy_pre", 16'(if0.busy), 16'h1);
        chk("mid.q_a0_pre", if0.q_a, 16'h5A5A);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.busy0", 16'(if0.busy), 16'h0);
        chk("mid.busy1", 16'(if1.busy), 16'h0);
        chk("mid.q_a0", if0.q_a, 16'h0);
        chk("mid.q_b1", if1.q_b, 16'h0);
        chk("mid.valid_a1", 16'(if1.valid_a), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_clear(1'b0, n0, n1, nv);
        chk("clr3.cycles0", 16'(n0), 16'd1024);
        chk("clr3.cycles1", 16'(n1), 16'd1024);

        // streaming reads on both ports
        for (int i = 0; i < 16; i++)
            cyc(1, 2'b11, 10'(i), 16'hA000 + 16'(i), 0, 2'b00, 10'h0, 16'h0);
        @(negedge clk);
        c0 = va0; c1 = vb0; c2 = va1; c3 = vb1;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 2'b00, 10'(i), 16'h0, 1, 2'b00, 10'(i), 16'h0);
            if (i == 0) begin
                chk("st.first_v0", 16'(if0.valid_a), 16'h1);
                chk("st.first_q0", if0.q_a, 16'hA000);
                chk("st.first_v1_early", 16'(if1.valid_a), 16'h0);
            end
            if (i == 1) begin
                chk("st.first_v1", 16'(if1.valid_a), 16'h1);
                chk("st.first_q1", if1.q_a, 16'hA000);
            end
        end
        repeat (2) @(negedge clk);
        chk("st.count_a0", 16'(va0 - c0), 16'd16);
        chk("st.count_b0", 16'(vb0 - c1), 16'd16);
        chk("st.count_a1", 16'(va1 - c2), 16'd16);
        chk("st.count_b1", 16'(vb1 - c3), 16'd16);
        chk("st.last_b1", if1.q_b, 16'hA00F);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/dpram_be.md
# dpram_be

Single-clock true dual-port RAM with per-lane byte enables, configurable read latency, selectable read-during-write mode, and a built-in memory-clear sequencer. It is the parametrised successor to the team's generic dual-port RAM: core-side buffers, video line stores and CPU/peripheral shared memories in single-clock designs. Two independent ports access one array; collisions resolve deterministically.

## Interface
- `dWidth`, 16: data width per port; must be a multiple of `bWidth`.
- `aWidth`, 10: address width; depth = 2**aWidth.
- `bWidth`, 8: byte-lane width; NB = dWidth/bWidth lanes.
- `RD_LAT`, 1: read latency in cycles, legal values 1 or 2 (2 adds an output register stage).
- `RDW_MODE`, 0: same-port read-during-write behaviour; 0 = write-first (new data), 1 = read-first (old data).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `clr` in 1: start memory clear; sampled only when idle.
- `busy` out 1: high while clear runs.
- `en_a` in 1: port A access request.
- `we_a` in NB: port A lane write enables; all zero = read.
- `addr_a` in aWidth: port A address.
- `d_a` in dWidth: port A write data.
- `q_a` out dWidth: port A read data.
- `valid_a` out 1: q_a carries the result of an accepted access.
- `en_b`, `we_b`, `addr_b`, `d_b`, `q_b`, `valid_b`: port B, identical to port A.
- `coll` out 1: collision pulse (see Configuration).

## Operation
- Reset values: q_a/q_b = 0, valid_a/valid_b = 0, busy = 0, coll = 0, clear counter = 0, FSM = IDLE. Array contents are not reset.
- Access accepted when en_x=1 and busy=0. Every access, read or write, returns data.
- Write: lanes with we_x[i]=1 are updated; other lanes keep their contents.
- Same-port read-during-write: RDW_MODE=0 returns the merged word (new lanes plus old unwritten lanes). RDW_MODE=1 returns the pre-write word.
- Cross-port read of an address the other port writes in the same cycle: always returns the pre-write word.
- Both ports write the same address in the same cycle: port A wins overlapping lanes. Each side's non-overlapping lanes are both written.
- Clear FSM states:
  - IDLE: on clr=1, go to CLEAR with counter=0.
  - CLEAR: write zero to ram[counter] and increment. After writing address 2**aWidth-1, return to IDLE; the counter wraps to 0.
  - busy = (state==CLEAR).
- During CLEAR, port requests are dropped: no write, valid low. clr while busy is ignored.
- Reset mid-clear: FSM goes to IDLE and busy drops immediately. Array is partially cleared; remaining contents are undefined.

## Timing
- Access sampled at edge T: q_x/valid_x are valid after edge T+RD_LAT, held for one cycle. valid_x=0 otherwise. q_x holds its last value when not valid.
- Write at edge T is visible to reads on either port sampled at edge T+1.
- Clear takes exactly 2**aWidth cycles. busy rises after the edge that samples clr and falls after the edge that writes the last address.
- A request at the first edge with busy=0 is accepted.
- With RD_LAT=2, pipelined accesses at full rate are supported on both ports: one result per port per cycle.

## Configuration
- `DPRAM_BE_COLLISION_EN` defined: coll pulses one cycle after an edge where both ports accepted accesses to the same address and at least one wrote. Aligned to RD_LAT=1 regardless of RD_LAT.
- Undefined: collision logic is compiled out and coll is tied 0. Array behaviour is identical either way.

## Structure
- Shared package `dpram_pkg`: RDW_MODE constants (`RDW_WRITE_FIRST`=0, `RDW_READ_FIRST`=1), the clear-FSM state typedef, and a lane-count function.
- Sub-module `dpram_clr_ctrl`: clear FSM and counter. Outputs busy, clear write enable and clear address; the top muxes these into the array write path.
- Parameter legality (dWidth % bWidth, RD_LAT in {1,2}) is checked at elaboration.

## Test plan
- Partial write: write A addr 0x010 d=0xBEEF we=2'b01, then read B addr 0x010 -> q_b low byte 0xEF, high byte unchanged from the prior 0x1234 (q_b=0x12EF) after RD_LAT cycles, valid_b pulse of 1 cycle.
- RDW modes: old word 0x0000, same-port write 0xAAAA we=2'b11 -> q_a=0xAAAA (RDW_MODE=0) or 0x0000 (RDW_MODE=1). The cross-port read the same cycle returns 0x0000 in both modes.
- Dual-write collision: A writes 0x1111 we=2'b11, B writes 0x2222 we=2'b10, same addr 0x3FF -> subsequent read 0x1111. coll=1 one cycle later when the macro is defined, 0 otherwise.
- Clear: fill memory with 0xFFFF, pulse clr -> busy high exactly 1024 cycles with aWidth=10. Requests during busy give valid=0. Afterwards every address reads 0x0000.
- Reset mid-clear: assert rst_n=0 at clear cycle 500 -> busy, valid and q drop to 0 asynchronously. After release, a new clr completes a full 1024-cycle clear.
- RD_LAT=2 streaming: back-to-back reads of addrs 0..15 on both ports -> 16 consecutive valid cycles per port, data in order, first result after 2 edges.
